morse_decoder: RTL

- Receive-side counterpart of the alphabet-to-Morse encoder. It times a keyed on/off signal, sorts each mark into a dot or a dash, and collects up to 4 symbols.
- On an inter-letter gap it emits the same 5-bit letter code the encoder consumes (A=1 … Z=26). It also flags word gaps and illegal patterns.
- It sits between the key/tone-detect front end and the character sink.

---
 rtl/morse_pkg.sv | 45 ++++
 rtl/morse_symbol_lut.sv | 55 +++++
 rtl/morse_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse letter codes, symbol values and decoder state type
//
// Purpose: letter codes (A=1 .. Z=26) shared with the encoder, the dot/dash
// symbol values stored in the pattern register, and the decoder FSM states.
// Ports: none (package).
package morse_pkg;

  localparam logic [4:0] L_A = 5'd1;
  localparam logic [4:0] L_B = 5'd2;
  localparam logic [4:0] L_C = 5'd3;
  localparam logic [4:0] L_D = 5'd4;
  localparam logic [4:0] L_E = 5'd5;
  localparam logic [4:0] L_F = 5'd6;
  localparam logic [4:0] L_G = 5'd7;
  localparam logic [4:0] L_H = 5'd8;
  localparam logic [4:0] L_I = 5'd9;
  localparam logic [4:0] L_J = 5'd10;
  localparam logic [4:0] L_K = 5'd11;
  localparam logic [4:0] L_L = 5'd12;
  localparam logic [4:0] L_M = 5'd13;
  localparam logic [4:0] L_N = 5'd14;
  localparam logic [4:0] L_O = 5'd15;
  localparam logic [4:0] L_P = 5'd16;
  localparam logic [4:0] L_Q = 5'd17;
  localparam logic [4:0] L_R = 5'd18;
  localparam logic [4:0] L_S = 5'd19;
  localparam logic [4:0] L_T = 5'd20;
  localparam logic [4:0] L_U = 5'd21;
  localparam logic [4:0] L_V = 5'd22;
  localparam logic [4:0] L_W = 5'd23;
  localparam logic [4:0] L_X = 5'd24;
  localparam logic [4:0] L_Y = 5'd25;
  localparam logic [4:0] L_Z = 5'd26;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    WGAP
  } state_t;

endpackage

// File: rtl/morse_symbol_lut.sv
// rtl/morse_symbol_lut.sv - combinational (length, pattern) to letter code lookup
//
// Purpose: inverse of the encoder tables. The first symbol is the MSB of the
// used bits of pattern; unused upper bits are always zero.
// Ports:
//   len     [2:0] in  - number of symbols collected (1..4 are meaningful)
//   pattern [3:0] in  - symbols, dot=0 dash=1, last symbol in bit 0
//   code    [4:0] out - letter code, 0 when not in the table
//   hit           out - pattern is a legal letter
module morse_symbol_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [3:0] pattern,
  output logic [4:0] code,
  output logic       hit
);

  always_comb begin
    code = 5'd0;
    case ({len, pattern})
      7'b001_0000: code = L_E;
      7'b001_0001: code = L_T;
      7'b010_0000: code = L_I;
      7'b010_0001: code = L_A;
      7'b010_0010: code = L_N;
      7'b010_0011: code = L_M;
      7'b011_0000: code = L_S;
      7'b011_0001: code = L_U;
      7'b011_0010: code = L_R;
      7'b011_0011: code = L_W;
      7'b011_0100: code = L_D;
      7'b011_0101: code = L_K;
      7'b011_0110: code = L_G;
      7'b011_0111: code = L_O;
      7'b100_0000: code = L_H;
      7'b100_0001: code = L_V;
      7'b100_0010: code = L_F;
      7'b100_0100: code = L_L;
      7'b100_0110: code = L_P;
      7'b100_0111: code = L_J;
      7'b100_1000: code = L_B;
      7'b100_1001: code = L_X;
      7'b100_1010: code = L_C;
      7'b100_1011: code = L_Y;
      7'b100_1100: code = L_Z;
      7'b100_1101: code = L_Q;
      default:     code = 5'd0;
    endcase
  end

  // Every table entry is non-zero, so a zero code means "not found".
  assign hit = (code != 5'd0);

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - keyed on/off timing to Morse letter code decoder
//
// Purpose: times marks and spaces of a raw key, classifies marks as dot or
// dash, collects up to 4 symbols and emits a letter code on a letter gap.
// Ports:
//   clk, rst       in  - clock, asynchronous active-high reset
//   en             in  - enable; low returns synchronously to IDLE
//   key_in         in  - raw key (1 = mark), asynchronous to clk
//   letter   [4:0] out - last decoded code, 0 after an error; held between emits
//   letter_valid   out - one-cycle pulse, letter is a legal code
//   letter_err     out - one-cycle pulse, illegal or over-long pattern
//   word_gap       out - one-cycle pulse, word gap seen
//   busy           out - state is not IDLE
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_MARK   = 2,
  parameter int DOT_MAX    = 4,
  parameter int GAP_LETTER = 8,
  parameter int GAP_WORD   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       key_in,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       word_gap,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_MARK_C = CNT_W'(MIN_MARK);
  localparam logic [CNT_W-1:0] DOT_MAX_C  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LET_C  = CNT_W'(GAP_LETTER);
  localparam logic [CNT_W-1:0] GAP_WORD_C = CNT_W'(GAP_WORD);

  logic             key_meta, key_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [2:0]       len, len_nxt;
  logic [3:0]       pattern, pattern_nxt;
  logic             ovf, ovf_nxt;
  logic [4:0]       letter_nxt;
  logic             valid_nxt, err_nxt, wgap_nxt;
  logic [4:0]       lut_code;
  logic             lut_hit;
  logic             sym;

  morse_symbol_lut u_lut (
    .len     (len),
    .pattern (pattern),
    .code    (lut_code),
    .hit     (lut_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  // Saturating so an arbitrarily long mark still classifies as a dash.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign sym     = (cnt > DOT_MAX_C) ? SYM_DASH : SYM_DOT;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    len_nxt     = len;
    pattern_nxt = pattern;
    ovf_nxt     = ovf;
    letter_nxt  = letter;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    wgap_nxt    = 1'b0;

    if (!en) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      len_nxt     = 3'd0;
      pattern_nxt = 4'd0;
      ovf_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_s) begin
            state_nxt = MARK;
            cnt_nxt   = CNT_ONE;
          end
        end
        MARK: begin
          if (key_s) begin
            cnt_nxt = cnt_inc;
          end else if (cnt < MIN_MARK_C) begin
            // Glitch: keep timing the gap only if a letter is in progress.
            if (len != 3'd0) begin
              state_nxt = SPACE;
              cnt_nxt   = CNT_ONE;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            if (len == 3'd4) begin
              ovf_nxt = 1'b1;
            end else begin
              pattern_nxt = {pattern[2:0], sym};
              len_nxt     = len + 3'd1;
            end
            state_nxt = SPACE;
            cnt_nxt   = CNT_ONE;
          end
        end
        SPACE: begin
          if (key_s) begin
            state_nxt = MARK;
            cnt_nxt   = CNT_ONE;
          end else begin
            if (cnt == GAP_LET_C) begin
              if (ovf || !lut_hit) begin
                err_nxt    = 1'b1;
                letter_nxt = 5'd0;
              end else begin
                valid_nxt  = 1'b1;
                letter_nxt = lut_code;
              end
              len_nxt     = 3'd0;
              pattern_nxt = 4'd0;
              ovf_nxt     = 1'b0;
              state_nxt   = WGAP;
            end
            cnt_nxt = cnt_inc;
          end
        end
        WGAP: begin
          if (key_s) begin
            state_nxt = MARK;
            cnt_nxt   = CNT_ONE;
          end else if (cnt == GAP_WORD_C) begin
            wgap_nxt  = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      len          <= 3'd0;
      pattern      <= 4'd0;
      ovf          <= 1'b0;
      letter       <= 5'd0;
      letter_valid <= 1'b0;
      letter_err   <= 1'b0;
      word_gap     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      len          <= len_nxt;
      pattern      <= pattern_nxt;
      ovf          <= ovf_nxt;
      letter       <= letter_nxt;
      letter_valid <= valid_nxt;
      letter_err   <= err_nxt;
      word_gap     <= wgap_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
